// File: rtl/vec_mac_pe.sv
// ---------------------------------------------------------------------------
// vec_mac_pe : vector multiply-accumulate processing element.
//
// Each accepted beat carries LANES signed neuron/weight pairs. Stage 1
// registers the full-precision sum of the lane products. Stage 2 folds that
// sum into a packet accumulator, either saturating (SAT=1) or wrapping
// (SAT=0). The last beat of a packet loads the output register, and the
// output is then held under a valid/ready handshake.
//
// Ports
//   clk     in   clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   neuron  in   LANES x DATA_W packed signed elements, lane i at [i*DATA_W +: DATA_W]
//   weight  in   LANES x DATA_W packed signed elements, same packing
//   ctl     in   bit0 = first beat of packet, bit1 = last beat of packet
//   vld_i   in   input beat valid
//   rdy_i   out  beat accepted when vld_i & rdy_i
//   result  out  ACC_W signed packet dot-product
//   ovf     out  saturation / wrap occurred somewhere in the reported packet
//   vld_o   out  result/ovf valid
//   rdy_o   in   result consumed when vld_o & rdy_o
// ---------------------------------------------------------------------------
module vec_mac_pe #(
    parameter int LANES  = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int SAT    = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic        [LANES*DATA_W-1:0] neuron,
    input  logic        [LANES*DATA_W-1:0] weight,
    input  logic        [1:0]              ctl,
    input  logic                           vld_i,
    output logic                           rdy_i,
    output logic signed [ACC_W-1:0]        result,
    output logic                           ovf,
    output logic                           vld_o,
    input  logic                           rdy_o
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = PROD_W + $clog2(LANES);

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Signed add of two ACC_W values. Returns {overflow, value}; the value is
    // clamped when SAT is set and wraps naturally otherwise.
    function automatic logic [ACC_W:0] f_acc_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
        logic signed [ACC_W:0]   s;
        logic                    o;
        logic signed [ACC_W-1:0] v;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        // The two top bits disagree exactly when the true sum left ACC_W range.
        o = s[ACC_W] ^ s[ACC_W-1];
        v = s[ACC_W-1:0];
        if (o && (SAT != 0)) begin
            v = s[ACC_W] ? ACC_MIN : ACC_MAX;
        end
        return {o, v};
    endfunction

    logic                    w_stall;
    logic                    w_accept;
    logic signed [PROD_W-1:0] w_prod [LANES];
    logic signed [SUM_W-1:0]  w_sum;

    logic signed [SUM_W-1:0]  r_sum_p1;
    logic                     r_first_p1;
    logic                     r_last_p1;
    logic                     r_vld_p1;

    logic signed [ACC_W-1:0]  r_acc_p2;
    logic                     r_sticky_p2;

    logic signed [ACC_W-1:0]  r_result;
    logic                     r_ovf;
    logic                     r_vld_o;

    logic                     w_go_p2;
    logic signed [ACC_W-1:0]  w_base_p2;
    logic signed [ACC_W-1:0]  w_sum_ext_p2;
    logic [ACC_W:0]           w_add_p2;
    logic signed [ACC_W-1:0]  w_acc_nxt_p2;
    logic                     w_sticky_nxt_p2;

    // The whole pipeline freezes while a finished result waits for downstream.
    assign w_stall  = r_vld_o & ~rdy_o;
    assign rdy_i    = ~w_stall;
    assign w_accept = vld_i & ~w_stall;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic signed [DATA_W-1:0] w_n;
        logic signed [DATA_W-1:0] w_w;
        assign w_n       = neuron[g*DATA_W +: DATA_W];
        assign w_w       = weight[g*DATA_W +: DATA_W];
        assign w_prod[g] = PROD_W'(w_n) * PROD_W'(w_w);
    end

    // The clog2(LANES) guard bits make this reduction exact.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_sum = w_sum + SUM_W'(w_prod[i]);
        end
    end

    // ---- stage 1 : lane product sum ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1   <= 1'b0;
            r_sum_p1   <= '0;
            r_first_p1 <= 1'b0;
            r_last_p1  <= 1'b0;
        end else if (!w_stall) begin
            r_vld_p1 <= w_accept;
            if (w_accept) begin
                r_sum_p1   <= w_sum;
                r_first_p1 <= ctl[0];
                r_last_p1  <= ctl[1];
            end
        end
    end

    // A first beat restarts from zero, so its own overflow is the only one
    // that can reach the sticky flag.
    assign w_go_p2         = r_vld_p1 & ~w_stall;
    assign w_base_p2       = r_first_p1 ? '0 : r_acc_p2;
    assign w_sum_ext_p2    = ACC_W'(r_sum_p1);
    assign w_add_p2        = f_acc_add(w_base_p2, w_sum_ext_p2);
    assign w_acc_nxt_p2    = w_add_p2[ACC_W-1:0];
    assign w_sticky_nxt_p2 = (r_first_p1 ? 1'b0 : r_sticky_p2) | w_add_p2[ACC_W];

    // ---- stage 2 : packet accumulator ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_p2    <= '0;
            r_sticky_p2 <= 1'b0;
        end else if (w_go_p2) begin
            r_acc_p2    <= w_acc_nxt_p2;
            r_sticky_p2 <= w_sticky_nxt_p2;
        end
    end

    // ---- output register ----
    // A new last beat may only load while not stalled, so a pending result
    // stays put until it is taken; on the taking cycle it may be replaced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_vld_o  <= 1'b0;
        end else if (w_go_p2 && r_last_p1) begin
            r_result <= w_acc_nxt_p2;
            r_ovf    <= w_sticky_nxt_p2;
            r_vld_o  <= 1'b1;
        end else if (r_vld_o && rdy_o) begin
            r_vld_o  <= 1'b0;
        end
    end

    assign result = r_result;
    assign ovf    = r_ovf;
    assign vld_o  = r_vld_o;

endmodule

// File: tb/tb_vec_mac_pe.sv
// ---------------------------------------------------------------------------
// tb_vec_mac_pe : self-checking bench for vec_mac_pe.
// Three instances share one stimulus stream: the default configuration
// (ACC_W=40, SAT=1) plus ACC_W=34 saturating and ACC_W=34 wrapping. An
// arithmetic reference model predicts every packet result per instance.
// ---------------------------------------------------------------------------
module tb_vec_mac_pe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] neuron;
    logic [63:0] weight;
    logic [1:0]  ctl;
    logic        vld_i;
    logic        rdy_o;
    logic        rdy_force;
    logic        rdy_mode;

    logic               rdy_i0, rdy_i1, rdy_i2;
    logic signed [39:0] res0;
    logic signed [33:0] res1, res2;
    logic               ovf0, ovf1, ovf2;
    logic               vld_o0, vld_o1, vld_o2;

    int checks = 0;
    int errors = 0;

    typedef struct { longint r; bit o; } exp_t;
    exp_t   q0[$], q1[$], q2[$];
    longint m_acc [3];
    bit     m_flg [3];

    always #5 clk = ~clk;

    // Downstream ready: either forced or randomly throttled.
    always @(posedge clk) begin
        #2;
        rdy_o = rdy_mode ? ($urandom_range(0, 3) != 0) : rdy_force;
    end

    vec_mac_pe #(.LANES(4), .DATA_W(16), .ACC_W(40), .SAT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .neuron(neuron), .weight(weight), .ctl(ctl),
        .vld_i(vld_i), .rdy_i(rdy_i0), .result(res0), .ovf(ovf0), .vld_o(vld_o0), .rdy_o(rdy_o));
    vec_mac_pe #(.LANES(4), .DATA_W(16), .ACC_W(34), .SAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .neuron(neuron), .weight(weight), .ctl(ctl),
        .vld_i(vld_i), .rdy_i(rdy_i1), .result(res1), .ovf(ovf1), .vld_o(vld_o1), .rdy_o(rdy_o));
    vec_mac_pe #(.LANES(4), .DATA_W(16), .ACC_W(34), .SAT(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .neuron(neuron), .weight(weight), .ctl(ctl),
        .vld_i(vld_i), .rdy_i(rdy_i2), .result(res2), .ovf(ovf2), .vld_o(vld_o2), .rdy_o(rdy_o));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rep(input logic signed [15:0] v);
        return {4{v}};
    endfunction

    // Reference: plain integer dot product, then accumulate with clamping or
    // modular wrap on a W-bit signed range.
    task automatic model_accept(input bit f, input bit l, input logic [63:0] n, input logic [63:0] w);
        longint dot, t, mx, mn, a;
        int     wd;
        bit     fl;
        logic signed [15:0] na, wa;
        exp_t   e;
        dot = 0;
        for (int i = 0; i < 4; i++) begin
            na = n[i*16 +: 16];
            wa = w[i*16 +: 16];
            dot += longint'(na) * longint'(wa);
        end
        for (int k = 0; k < 3; k++) begin
            wd = (k == 0) ? 40 : 34;
            mx = (longint'(1) << (wd - 1)) - 1;
            mn = -mx - 1;
            t  = f ? dot : m_acc[k] + dot;
            fl = f ? 1'b0 : m_flg[k];
            a  = t;
            if (t > mx) begin
                fl = 1'b1;
                a  = (k == 2) ? t - (longint'(1) << wd) : mx;
            end else if (t < mn) begin
                fl = 1'b1;
                a  = (k == 2) ? t + (longint'(1) << wd) : mn;
            end
            m_acc[k] = a;
            m_flg[k] = fl;
            if (l) begin
                e.r = a;
                e.o = fl;
                if (k == 0) q0.push_back(e);
                else if (k == 1) q1.push_back(e);
                else q2.push_back(e);
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_acc[k] = 0;
            m_flg[k] = 1'b0;
        end
    endtask

    // Checks every handshake, hold-during-stall, and each delivered result.
    task automatic monitor();
        bit             prev_stall = 1'b0;
        logic [39:0]    held_r;
        logic           held_o;
        exp_t           e;
        logic [63:0]    ev;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("rdy_i", {63'd0, rdy_i0}, {63'd0, !(vld_o0 && !rdy_o)});
                if (prev_stall && vld_o0) begin
                    chk("hold_result", {24'd0, res0}, {24'd0, held_r});
                    chk("hold_ovf", {63'd0, ovf0}, {63'd0, held_o});
                end
                prev_stall = vld_o0 && !rdy_o;
                held_r     = res0;
                held_o     = ovf0;
                if (vld_o0 && rdy_o) begin
                    if (q0.size() == 0) chk("spurious_vld0", {63'd0, vld_o0}, 64'd0);
                    else begin
                        e  = q0.pop_front();
                        ev = e.r;
                        chk("res40", {24'd0, res0}, {24'd0, ev[39:0]});
                        chk("ovf40", {63'd0, ovf0}, {63'd0, e.o});
                    end
                end
                if (vld_o1 && rdy_o) begin
                    if (q1.size() == 0) chk("spurious_vld1", {63'd0, vld_o1}, 64'd0);
                    else begin
                        e  = q1.pop_front();
                        ev = e.r;
                        chk("res34s", {30'd0, res1}, {30'd0, ev[33:0]});
                        chk("ovf34s", {63'd0, ovf1}, {63'd0, e.o});
                    end
                end
                if (vld_o2 && rdy_o) begin
                    if (q2.size() == 0) chk("spurious_vld2", {63'd0, vld_o2}, 64'd0);
                    else begin
                        e  = q2.pop_front();
                        ev = e.r;
                        chk("res34w", {30'd0, res2}, {30'd0, ev[33:0]});
                        chk("ovf34w", {63'd0, ovf2}, {63'd0, e.o});
                    end
                end
            end else begin
                prev_stall = 1'b0;
            end
        end
    endtask

    // Present one beat and hold it until accepted; returns #1 after the edge.
    task automatic send(input bit f, input bit l, input logic [63:0] n, input logic [63:0] w);
        bit acc;
        vld_i  = 1'b1;
        ctl    = {l, f};
        neuron = n;
        weight = w;
        acc    = 1'b0;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            acc = rdy_i0;
            if (acc) model_accept(f, l, n, w);
            @(posedge clk);
            #1;
        end
        if (!acc) chk("accept_timeout", {63'd0, acc}, 64'd1);
        vld_i = 1'b0;
    endtask

    task automatic wait_vld(input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            seen = vld_o0;
            if (!seen) begin
                @(posedge clk);
                #1;
            end
        end
        if (!seen) chk(tag, {63'd0, vld_o0}, 64'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 1000 && (q0.size() + q1.size() + q2.size()) != 0; k++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_q0", 64'(q0.size()), 64'd0);
        chk("drain_q2", 64'(q2.size()), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        vld_i     = 1'b0;
        ctl       = 2'b11;
        neuron    = '0;
        weight    = '0;
        rdy_force = 1'b1;
        rdy_mode  = 1'b0;
        model_reset();
        fork
            monitor();
        join_none

        #12;
        chk("rst_vld_o", {63'd0, vld_o0}, 64'd0);
        chk("rst_result", {24'd0, res0}, 64'd0);
        chk("rst_ovf", {63'd0, ovf0}, 64'd0);
        chk("rst_rdy_i", {63'd0, rdy_i0}, 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single beat, latency and one-cycle valid pulse.
        send(1, 1, {16'd4, 16'd3, 16'd2, 16'd1}, {16'd8, 16'd7, 16'd6, 16'd5});
        @(negedge clk);
        chk("lat_cycle1", {63'd0, vld_o0}, 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("lat_cycle2", {63'd0, vld_o0}, 64'd1);
        chk("dot70", {24'd0, res0}, 64'd70);
        chk("dot70_ovf", {63'd0, ovf0}, 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("vld_drop", {63'd0, vld_o0}, 64'd0);
        @(posedge clk);
        #1;

        // Three-beat packet then an independent single-beat packet.
        send(1, 0, rep(16'sd100), rep(-16'sd3));
        send(0, 0, rep(16'sd100), rep(-16'sd3));
        send(0, 1, rep(16'sd100), rep(-16'sd3));
        send(1, 1, rep(16'sd1), rep(16'sd1));
        wait_vld("wait_m3600");
        chk("dot_m3600", {24'd0, res0}, {24'd0, 40'sh0 - 40'sd3600});
        @(posedge clk);
        #1;
        wait_vld("wait_4");
        chk("dot_4", {24'd0, res0}, 64'd4);
        drain();

        // Packet starting with first=0 after a fresh reset accumulates onto zero.
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(0, 1, rep(16'sd7), rep(16'sd9));
        wait_vld("wait_252");
        chk("dot_252", {24'd0, res0}, 64'd252);
        drain();

        // Backpressure: result held, beats refused, nothing lost on release.
        rdy_force = 1'b0;
        @(posedge clk);
        #1;
        send(1, 1, rep(16'sd1), rep(16'sd10));
        send(1, 1, rep(16'sd1), rep(16'sd20));
        vld_i  = 1'b1;
        ctl    = 2'b11;
        neuron = rep(16'sd1);
        weight = rep(16'sd30);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_rdy_i", {63'd0, rdy_i0}, 64'd0);
            chk("bp_vld_o", {63'd0, vld_o0}, 64'd1);
            chk("bp_result", {24'd0, res0}, 64'd40);
            @(posedge clk);
            #1;
        end
        rdy_force = 1'b1;
        send(1, 1, rep(16'sd1), rep(16'sd30));
        drain();

        // Overflow: 8 beats of max positive products.
        for (int b = 0; b < 8; b++) begin
            send(b == 0, b == 7, rep(16'sd32767), rep(16'sd32767));
        end
        wait_vld("wait_ovf");
        chk("sat34_result", {30'd0, res1}, {30'd0, 34'h1_FFFF_FFFF});
        chk("sat34_ovf", {63'd0, ovf1}, 64'd1);
        chk("wrap34_result", {30'd0, res2}, {30'd0, 34'sh0 - 34'sd2097120});
        chk("wrap34_ovf", {63'd0, ovf2}, 64'd1);
        drain();

        // Reset in the middle of a packet discards the partial sum.
        send(1, 0, rep(16'sd1000), rep(16'sd1000));
        send(0, 0, rep(16'sd1000), rep(16'sd1000));
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_vld_o", {63'd0, vld_o0}, 64'd0);
        chk("midrst_rdy_i", {63'd0, rdy_i0}, 64'd1);
        chk("midrst_result", {24'd0, res0}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(1, 1, rep(16'sd2), rep(16'sd3));
        wait_vld("wait_24");
        chk("dot_24", {24'd0, res0}, 64'd24);
        drain();

        // Random packets with input gaps and random downstream throttling.
        rdy_mode = 1'b1;
        for (int p = 0; p < 30; p++) begin
            int len;
            len = $urandom_range(1, 20);
            for (int b = 0; b < len; b++) begin
                int idle;
                idle = $urandom_range(0, 2);
                for (int g = 0; g < idle; g++) begin
                    vld_i  = 1'b0;
                    ctl    = 2'($urandom);
                    neuron = {$urandom, $urandom};
                    weight = {$urandom, $urandom};
                    @(posedge clk);
                    #1;
                end
                send(b == 0, b == len - 1, {$urandom, $urandom}, {$urandom, $urandom});
            end
        end
        rdy_mode = 1'b0;
        drain();
        chk("final_q1", 64'(q1.size()), 64'd0);
        @(negedge clk);
        chk("final_vld_o", {63'd0, vld_o0}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
